// File: rtl/bus_splitter.sv
// Single-initiator to three-target bus demultiplexer with address-window decode and local fault completion.
// Optional ACTIVE-state timeout abort is compiled in with `define BUS_SPLITTER_TIMEOUT_EN.
module bus_splitter #(
    parameter logic [31:0] T0_BASE        = 32'h0000_0000,
    parameter logic [31:0] T0_MASK        = 32'hF000_0000,
    parameter logic [31:0] T1_BASE        = 32'h5000_0000,
    parameter logic [31:0] T1_MASK        = 32'hF000_0000,
    parameter logic [31:0] T2_BASE        = 32'h8000_0000,
    parameter logic [31:0] T2_MASK        = 32'hF000_0000,
    parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_rw,
    input  logic        i_bus_request,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_rdata,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_wmask,
    output logic        o_t0_rw,
    output logic        o_t0_request,
    output logic [31:0] o_t0_address,
    output logic [31:0] o_t0_wdata,
    output logic [3:0]  o_t0_wmask,
    input  logic        i_t0_ready,
    input  logic [31:0] i_t0_rdata,
    output logic        o_t1_rw,
    output logic        o_t1_request,
    output logic [31:0] o_t1_address,
    output logic [31:0] o_t1_wdata,
    output logic [3:0]  o_t1_wmask,
    input  logic        i_t1_ready,
    input  logic [31:0] i_t1_rdata,
    output logic        o_t2_rw,
    output logic        o_t2_request,
    output logic [31:0] o_t2_address,
    output logic [31:0] o_t2_wdata,
    output logic [3:0]  o_t2_wmask,
    input  logic        i_t2_ready,
    input  logic [31:0] i_t2_rdata,
    output logic        o_fault,
    output logic [31:0] o_fault_address
);

    typedef enum logic [1:0] {IDLE, ACTIVE, UNMAPPED} state_t;

    localparam logic [31:0] BASES [3] = '{T0_BASE, T1_BASE, T2_BASE};
    localparam logic [31:0] MASKS [3] = '{T0_MASK, T1_MASK, T2_MASK};

    state_t      state_reg, state_next;
    logic [1:0]  sel_reg, sel_next;
    logic [31:0] fault_address_reg, fault_address_next;

    logic [2:0]  hit;
    logic [2:0]  t_sel;
    logic [2:0]  t_ready;
    logic [31:0] t_rdata [3];
    logic [2:0]  t_req_vec;
    logic [2:0]  t_rw_vec;
    logic [31:0] t_addr_vec  [3];
    logic [31:0] t_wdata_vec [3];
    logic [3:0]  t_wmask_vec [3];
    logic [1:0]  dec_sel;
    logic        dec_hit;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;

    assign t_ready    = {i_t2_ready, i_t1_ready, i_t0_ready};
    assign t_rdata[0] = i_t0_rdata;
    assign t_rdata[1] = i_t1_rdata;
    assign t_rdata[2] = i_t2_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_target
            assign hit[gi]         = (i_bus_address & MASKS[gi]) == BASES[gi];
            assign t_sel[gi]       = (state_reg == ACTIVE) && (sel_reg == 2'(gi));
            // Request drops the same cycle the initiator withdraws or the timeout fires.
            assign t_req_vec[gi]   = t_sel[gi] & i_bus_request & ~timeout_hit;
            assign t_rw_vec[gi]    = t_sel[gi] & i_bus_rw;
            assign t_addr_vec[gi]  = t_sel[gi] ? i_bus_address : 32'h0;
            assign t_wdata_vec[gi] = t_sel[gi] ? i_bus_wdata   : 32'h0;
            assign t_wmask_vec[gi] = t_sel[gi] ? i_bus_wmask   : 4'h0;
        end
    endgenerate

    assign dec_hit = |hit;
    assign dec_sel = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        case (sel_reg)
            2'd0:    begin sel_ready = t_ready[0]; sel_rdata = t_rdata[0]; end
            2'd1:    begin sel_ready = t_ready[1]; sel_rdata = t_rdata[1]; end
            2'd2:    begin sel_ready = t_ready[2]; sel_rdata = t_rdata[2]; end
            default: begin sel_ready = 1'b0;       sel_rdata = 32'h0;      end
        endcase
    end

`ifdef BUS_SPLITTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;

    always_ff @(posedge i_clock) begin
        if (i_reset || state_reg != ACTIVE) begin
            tmo_cnt_reg <= 16'h0;
        end else if (!sel_ready) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'h1;
        end
    end

    // A target ready in the expiry cycle wins over the abort.
    assign timeout_hit = (state_reg == ACTIVE) && i_bus_request && !sel_ready &&
                         (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg         <= IDLE;
            sel_reg           <= 2'd0;
            fault_address_reg <= 32'h0;
        end else begin
            state_reg         <= state_next;
            sel_reg           <= sel_next;
            fault_address_reg <= fault_address_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        sel_next           = sel_reg;
        fault_address_next = fault_address_reg;
        o_bus_ready        = 1'b0;
        o_bus_rdata        = 32'h0;
        o_fault            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_bus_request) begin
                    sel_next = dec_sel;
                    if (dec_hit) begin
                        state_next = ACTIVE;
                    end else begin
                        state_next         = UNMAPPED;
                        fault_address_next = i_bus_address;
                    end
                end
            end
            ACTIVE: begin
                o_bus_ready = (sel_ready & i_bus_request) | timeout_hit;
                o_bus_rdata = timeout_hit ? UNMAPPED_RDATA : sel_rdata;
                o_fault     = timeout_hit;
                if (timeout_hit) begin
                    fault_address_next = i_bus_address;
                end
                if (!i_bus_request || sel_ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            UNMAPPED: begin
                o_bus_ready = 1'b1;
                o_bus_rdata = UNMAPPED_RDATA;
                o_fault     = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_fault_address = fault_address_reg;

    assign o_t0_request = t_req_vec[0];
    assign o_t0_rw      = t_rw_vec[0];
    assign o_t0_address = t_addr_vec[0];
    assign o_t0_wdata   = t_wdata_vec[0];
    assign o_t0_wmask   = t_wmask_vec[0];
    assign o_t1_request = t_req_vec[1];
    assign o_t1_rw      = t_rw_vec[1];
    assign o_t1_address = t_addr_vec[1];
    assign o_t1_wdata   = t_wdata_vec[1];
    assign o_t1_wmask   = t_wmask_vec[1];
    assign o_t2_request = t_req_vec[2];
    assign o_t2_rw      = t_rw_vec[2];
    assign o_t2_address = t_addr_vec[2];
    assign o_t2_wdata   = t_wdata_vec[2];
    assign o_t2_wmask   = t_wmask_vec[2];

endmodule
